bias_fetch_32x16b: RTL and testbench

Bias-stream reader feeding the 32-lane 16-bit bias adder. On a start command it reads a run of 512-bit bias words from the bias RAM, which has a fixed read latency. It buffers the returned words in a small show-ahead FIFO and presents them on the adder's RAM-data input, one word consumed per cycle the adder's calculate enable is high. It owns address generation, read-latency tracking, flow control and run completion.

---
 rtl/bias_fetch_32x16b_if.sv | 22 ++
 rtl/bias_fetch_32x16b.sv | 154 +++++++++++++++
 tb/tb_bias_fetch_32x16b.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bias_fetch_32x16b_if.sv
// RAM read port and adder-side data port of the bias fetcher.
// master = fetcher (drives RAM strobe/address and adder data), slave = RAM + adder.
interface bias_fetch_32x16b_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  o_ram_rd_en;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [511:0]          i_ram_rd_dat;
    logic                  i_calc_en;
    logic [511:0]          o_ram_dat;
    logic                  o_dat_vld;

    modport master (
        output o_ram_rd_en, o_ram_addr, o_ram_dat, o_dat_vld,
        input  i_ram_rd_dat, i_calc_en
    );

    modport slave (
        input  o_ram_rd_en, o_ram_addr, o_ram_dat, o_dat_vld,
        output i_ram_rd_dat, i_calc_en
    );
endinterface

// File: rtl/bias_fetch_32x16b.sv
// Bias-stream reader: issues a run of RAM reads into a show-ahead FIFO feeding the bias adder; optional BIAS_FETCH_UNDERFLOW_EN.
// Latency start->first word visible = RAM_RD_LAT+2; reads are credit-limited by FIFO space, adder pops via i_calc_en.
module bias_fetch_32x16b #(
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_RD_LAT = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underflow,
    bias_fetch_32x16b_if.master   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RAM_RD_LAT + 1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rd_rem_q, rd_rem_d;
    logic [ADDR_WIDTH-1:0] pop_rem_q, pop_rem_d;
    logic [RAM_RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [511:0]          mem_q [FIFO_DEPTH];

    logic [CW-1:0]         outstanding;
    logic                  rd_en;
    logic                  push;
    logic                  pop;
    logic                  start_acc;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            outstanding = outstanding + CW'(vld_sr_q[i]);
        end
    end

    // Reads in flight are counted as already occupying FIFO slots, so the FIFO can never overflow.
    assign start_acc = (state_q == S_IDLE) && i_start;
    assign rd_en     = (state_q == S_FETCH) && (rd_rem_q != '0)
                       && ((outstanding + cnt_q) < CW'(FIFO_DEPTH));
    assign push      = vld_sr_q[RAM_RD_LAT-1];
    assign pop       = bus.i_calc_en && (cnt_q != '0);

    generate
        if (RAM_RD_LAT == 1) begin : g_sr1
            assign vld_sr_d = rd_en;
        end else begin : g_srn
            assign vld_sr_d = {vld_sr_q[RAM_RD_LAT-2:0], rd_en};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_rem_d  = rd_rem_q;
        pop_rem_d = pop_rem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        if (rd_en) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            rd_rem_d = rd_rem_q - ADDR_WIDTH'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    addr_d    = i_base_addr;
                    rd_rem_d  = i_len;
                    pop_rem_d = i_len;
                    if (i_len == '0) done_d  = 1'b1;
                    else             state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (pop) begin
                    pop_rem_d = pop_rem_q - ADDR_WIDTH'(1);
                    if (pop_rem_q == ADDR_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rd_rem_q  <= '0;
            pop_rem_q <= '0;
            vld_sr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_rem_q  <= rd_rem_d;
            pop_rem_q <= pop_rem_d;
            vld_sr_q  <= vld_sr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_ram_rd_dat;
    end

`ifdef BIAS_FETCH_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc) begin
            underflow_q <= 1'b0;
        end else if (bus.i_calc_en && (cnt_q == '0)) begin
            underflow_q <= 1'b1;
        end
    end

    assign o_underflow = underflow_q;
`else
    assign o_underflow = 1'b0;
`endif

    assign o_busy          = (state_q == S_FETCH);
    assign o_done          = done_q;
    assign bus.o_ram_rd_en = rd_en;
    assign bus.o_ram_addr  = addr_q;
    assign bus.o_dat_vld   = (cnt_q != '0);
    assign bus.o_ram_dat   = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_bias_fetch_32x16b.sv
// Bench for bias_fetch_32x16b: random RAM contents, directed and random runs against a word-stream reference.
module tb_bias_fetch_32x16b;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int BUDGET = 400;
`ifdef BIAS_FETCH_UNDERFLOW_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          underflow;

    bias_fetch_32x16b_if #(.ADDR_WIDTH(AW)) bus ();

    bias_fetch_32x16b #(.ADDR_WIDTH(AW), .RAM_RD_LAT(LAT), .FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_underflow (underflow),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // RAM model: address captured on every edge, data returned LAT cycles later.
    logic [511:0]  ram [1024];
    logic [AW-1:0] ram_pipe [LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= bus.o_ram_addr;
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign bus.i_ram_rd_dat = ram[ram_pipe[LAT-1]];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from the current cycle (cycle 0). mode 0: calc always high,
    // mode 1: calc low until rel, mode 2: random calc and random ignored starts.
    task automatic do_run(input logic [AW-1:0] b, input logic [AW-1:0] n,
                          input int mode, input int rel);
        logic [511:0]  exp_dat [$];
        logic [AW-1:0] exp_addr [$];
        int first_rd = -1, last_rd = -1, first_vld = -1, done_cyc = -1;
        int n_rd = 0, n_done = 0;
        bit seen = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            exp_addr.push_back(AW'((int'(b) + k) % 1024));
            exp_dat.push_back(ram[(int'(b) + k) % 1024]);
        end
        start = 1'b1; base_addr = b; len = n;
        bus.i_calc_en = (mode == 0);
        for (int c = 1; c <= BUDGET && !seen; c++) begin
            tick();
            start = 1'b0;
            case (mode)
                0: bus.i_calc_en = 1'b1;
                1: bus.i_calc_en = (c >= rel);
                default: begin
                    bus.i_calc_en = 1'($urandom_range(0, 1));
                    if (busy) begin
                        start = 1'($urandom_range(0, 1));
                        base_addr = AW'($urandom);
                        len = AW'($urandom);
                    end
                end
            endcase
            if (c == 1) chk("busy_at_1", 512'(busy), 512'(1));
            if (bus.o_ram_rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                if (exp_addr.size() == 0) chk("rd_extra", 512'(1), 512'(0));
                else chk("rd_addr", 512'(bus.o_ram_addr), 512'(exp_addr.pop_front()));
            end
            if (bus.o_dat_vld && first_vld < 0) first_vld = c;
            if (bus.o_dat_vld && bus.i_calc_en) begin
                if (exp_dat.size() == 0) chk("pop_extra", 512'(1), 512'(0));
                else chk("pop_dat", bus.o_ram_dat, exp_dat.pop_front());
            end
            if (mode == 1 && c == rel - 1) begin
                chk("stall_rd_cnt", 512'(n_rd), 512'(4));
                chk("stall_vld", 512'(bus.o_dat_vld), 512'(1));
                chk("stall_head", bus.o_ram_dat, ram[b]);
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                seen = 1'b1;
                chk("done_not_busy", 512'(busy), 512'(0));
                start = 1'b0;
                bus.i_calc_en = 1'b0;
            end
        end
        if (!seen) chk("done_timeout", 512'(0), 512'(1));
        tick();
        chk("done_one_cycle", 512'(done), 512'(0));
        chk("rd_count", 512'(n_rd), 512'(n));
        chk("words_left", 512'(exp_dat.size()), 512'(0));
        chk("done_count", 512'(n_done), 512'(1));
        chk("first_rd_cyc", 512'(first_rd), 512'(1));
        if (mode == 0) begin
            chk("last_rd_cyc", 512'(last_rd), 512'(n));
            chk("first_vld_cyc", 512'(first_vld), 512'(LAT + 2));
            chk("done_cyc", 512'(done_cyc), 512'(int'(n) + LAT + 2));
        end
    endtask

    initial begin
        int cnt_rd, cnt_bad;
        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 16; j++) ram[i][j*32 +: 32] = $urandom;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; bus.i_calc_en = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_rd_en", 512'(bus.o_ram_rd_en), 512'(0));
        chk("rst_addr", 512'(bus.o_ram_addr), 512'(0));
        chk("rst_vld", 512'(bus.o_dat_vld), 512'(0));
        chk("rst_dat", bus.o_ram_dat, 512'(0));
        chk("rst_uf", 512'(underflow), 512'(0));
        rst = 1'b0;
        cnt_rd = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.o_ram_rd_en || bus.o_dat_vld || done || busy) cnt_rd++;
        end
        chk("idle_quiet", 512'(cnt_rd), 512'(0));

        do_run(10'h010, 10'd8, 0, 0);
        do_run(10'h010, 10'd8, 1, 20);
        do_run(10'h3FE, 10'd4, 0, 0);

        // Zero-length run: immediate done, no reads, then an empty pop.
        start = 1'b1; base_addr = 10'h055; len = 10'd0;
        tick();
        start = 1'b0;
        chk("len0_done", 512'(done), 512'(1));
        chk("len0_busy", 512'(busy), 512'(0));
        chk("len0_rd_en", 512'(bus.o_ram_rd_en), 512'(0));
        chk("len0_uf_clear", 512'(underflow), 512'(0));
        tick();
        chk("len0_done_once", 512'(done), 512'(0));
        bus.i_calc_en = 1'b1;
        tick();
        bus.i_calc_en = 1'b0;
        tick();
        chk("len0_underflow", 512'(underflow), 512'(UF_EXP));

        // Reset in the middle of an 8-word run.
        start = 1'b1; base_addr = 10'h100; len = 10'd8; bus.i_calc_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_done", 512'(done), 512'(0));
        chk("mid_rst_rd_en", 512'(bus.o_ram_rd_en), 512'(0));
        chk("mid_rst_addr", 512'(bus.o_ram_addr), 512'(0));
        chk("mid_rst_vld", 512'(bus.o_dat_vld), 512'(0));
        chk("mid_rst_dat", bus.o_ram_dat, 512'(0));
        chk("mid_rst_uf", 512'(underflow), 512'(0));
        rst = 1'b0;
        bus.i_calc_en = 1'b0;
        cnt_bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || bus.o_dat_vld || bus.o_ram_rd_en) cnt_bad++;
        end
        chk("post_rst_quiet", 512'(cnt_bad), 512'(0));
        do_run(10'h020, 10'd2, 0, 0);

        for (int r = 0; r < 4; r++) begin
            do_run(AW'($urandom), AW'($urandom_range(1, 24)), 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
